bram_infer: RTL and testbench
=============================

// Module: bram_infer
//
// PURPOSE
// - Signed two's-complement saturating adder for the LDPC decoder datapath (LLR/message accumulation).
// - Combinational saturated sum c = sat(a + b): never wraps, clamps to the signed range.
// - Also provides a registered copy with valid flag, per-direction saturation flags and a saturation event counter.
//
// PARAMETERS
// - WIDTH    16  operand/result width, signed; min 2
// - CNT_W    16  saturation event counter width
//
// PORTS
// - clk        in   1        single clock; all registers on rising edge
// - rst        in   1        asynchronous, active-low reset (asserted when 0)
// - a          in   WIDTH    operand A, signed two's complement
// - b          in   WIDTH    operand B, signed two's complement
// - in_valid   in   1        qualifies a/b for the registered stage
// - cnt_clr    in   1        synchronous clear of sat_cnt
// - c          out  WIDTH    combinational saturated sum
// - sat_pos    out  1        combinational: positive overflow clamped this cycle
// - sat_neg    out  1        combinational: negative overflow clamped this cycle
// - c_q        out  WIDTH    registered c
// - sat_pos_q  out  1        registered sat_pos
// - sat_neg_q  out  1        registered sat_neg
// - out_valid  out  1        c_q/flags hold a fresh result
// - sat_cnt    out  CNT_W    number of valid saturated additions
//
// BEHAVIOUR
// - Arithmetic: s = a + b at WIDTH+1 bits (sign-extended operands).
//   - s > 2^(WIDTH-1)-1  -> c = MAX (0x7FFF @16), sat_pos = 1
//   - s < -2^(WIDTH-1)   -> c = MIN (0x8000 @16), sat_neg = 1
//   - otherwise c = s[WIDTH-1:0], both flags 0
//   - Equivalent: overflow iff sign(a)==sign(b) and sign(wrapped sum) != sign(a); clamp toward sign(a).
//   - Exact MAX or MIN results are NOT saturation (flags 0). sat_pos and sat_neg never both 1.
// - c, sat_pos, sat_neg: purely combinational, zero latency, independent of clk and rst.
// - Registered stage (latency 1):
//   - in_valid=1 at edge -> c_q, sat_pos_q, sat_neg_q <= combinational values; out_valid <= 1.
//   - in_valid=0 at edge -> out_valid <= 0; c_q and flags hold their value.
// - sat_cnt:
//   - +1 on each edge with in_valid & (sat_pos|sat_neg).
//   - Sticks at all-ones, no wrap.
//   - cnt_clr has priority over increment: clears to 0 on that edge.
// - Reset (rst=0):
//   - immediately c_q=0, sat_pos_q=0, sat_neg_q=0, out_valid=0, sat_cnt=0.
//   - Held while low; combinational outputs keep tracking a/b.
//   - Reset mid-stream discards the in-flight result; first out_valid after release comes one edge after first in_valid.
// - No X propagation from the register stage after reset; no internal state besides listed registers.
//
// TESTING
// - a=3, b=-2 -> c=1 ; a=3, b=13 -> c=16 ; a=-30, b=-123 -> c=-153 ; all flags 0.
// - a=32000, b=1000 -> c=32767, sat_pos=1 ; a=-2000, b=-32500 -> c=-32768, sat_neg=1.
// - a=-32767, b=-1 -> c=-32768 (exact), flags 0 ; a=32767, b=-32768 -> c=-1, flags 0.
// - Registered path:
//   - in_valid=1 for 3 edges (3+13, 32000+1000, -30+-123).
//   - c_q/out_valid follow one edge later; sat_cnt ends at 1.
//   - Drop in_valid -> out_valid=0 and c_q holds -153.
// - Counter: CNT_W=2, 5 saturating valid adds -> sat_cnt=3 (sticky).
//   - Then cnt_clr with a saturating valid add on the same edge -> 0.
// - Async reset: pulse rst low between edges mid-stream -> c_q, out_valid, sat_cnt go 0 without a clock edge.
//   - c keeps tracking a/b throughout.
//   - Outputs resume on the first in_valid edge after release.

Source files
------------

// File: rtl/bram_infer.sv
// Signed saturating adder for LDPC LLR/message accumulation.
// Provides a combinational clamp, a one-deep registered copy and a sticky saturation counter.

module bram_infer_satadd #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             sat_pos,
  output logic             sat_neg
);
  logic [WIDTH:0] s;

  // One guard bit: the top two bits of the sum disagree exactly on overflow.
  always_comb begin
    s       = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    sat_pos = (s[WIDTH:WIDTH-1] == 2'b01);
    sat_neg = (s[WIDTH:WIDTH-1] == 2'b10);
    if (sat_pos)
      c = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sat_neg)
      c = {1'b1, {(WIDTH-1){1'b0}}};
    else
      c = s[WIDTH-1:0];
  end
endmodule

module bram_infer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] c,
  output logic             sat_pos,
  output logic             sat_neg,
  output logic [WIDTH-1:0] c_q,
  output logic             sat_pos_q,
  output logic             sat_neg_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam int STAGES = 1;

  logic [STAGES:0] vld_pipe;
  logic            sat_any;

  bram_infer_satadd #(.WIDTH(WIDTH)) u_add (
    .a       (a),
    .b       (b),
    .c       (c),
    .sat_pos (sat_pos),
    .sat_neg (sat_neg)
  );

  assign vld_pipe[0] = in_valid;
  assign sat_any     = sat_pos | sat_neg;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end
  end

  // Data and flags only load on valid so they hold across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q       <= '0;
      sat_pos_q <= 1'b0;
      sat_neg_q <= 1'b0;
    end else if (in_valid) begin
      c_q       <= c;
      sat_pos_q <= sat_pos;
      sat_neg_q <= sat_neg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sat_cnt <= '0;
    else if (cnt_clr)
      sat_cnt <= '0;
    else if (in_valid && sat_any && (sat_cnt != {CNT_W{1'b1}}))
      sat_cnt <= sat_cnt + 1'b1;
  end
endmodule

// File: tb/tb_bram_infer.sv
// Bench for bram_infer: directed spec vectors, random sums vs an integer model,
// a narrow-counter instance for stickiness, and an asynchronous reset pulse.

module tb_bram_infer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_valid = 1'b0, cnt_clr = 1'b0;
  logic [15:0] c, c_q;
  logic        sat_pos, sat_neg, sat_pos_q, sat_neg_q, out_valid;
  logic [15:0] sat_cnt;

  logic [15:0] a2 = '0, b2 = '0;
  logic        v2 = 1'b0, clr2 = 1'b0;
  logic [15:0] c2, c2_q;
  logic        sp2, sn2, sp2_q, sn2_q, ov2;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  // reference state for the registered path of the main instance
  logic [15:0] m_cq;
  logic        m_pq, m_nq, m_ov;
  int          m_cnt;

  always #5 clk = ~clk;

  bram_infer #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .c(c), .sat_pos(sat_pos), .sat_neg(sat_neg), .c_q(c_q),
    .sat_pos_q(sat_pos_q), .sat_neg_q(sat_neg_q), .out_valid(out_valid), .sat_cnt(sat_cnt)
  );

  bram_infer #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(v2), .cnt_clr(clr2),
    .c(c2), .sat_pos(sp2), .sat_neg(sn2), .c_q(c2_q),
    .sat_pos_q(sp2_q), .sat_neg_q(sn2_q), .out_valid(ov2), .sat_cnt(cnt2)
  );

  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic p, output logic n);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    p = 1'b0;
    n = 1'b0;
    if (s > 32767) begin
      r = 16'h7fff; p = 1'b1;
    end else if (s < -32768) begin
      r = 16'h8000; n = 1'b1;
    end else begin
      r = 16'(s);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    logic [15:0] r;
    logic p, n;
    model(a, b, r, p, n);
    chk({tag, ".c"}, c, r);
    chk({tag, ".sat_pos"}, sat_pos, p);
    chk({tag, ".sat_neg"}, sat_neg, n);
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, ".c_q"}, c_q, m_cq);
    chk({tag, ".sat_pos_q"}, sat_pos_q, m_pq);
    chk({tag, ".sat_neg_q"}, sat_neg_q, m_nq);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    chk({tag, ".sat_cnt"}, sat_cnt, m_cnt);
  endtask

  // one clock of the main instance: drive, check comb, clock, check registered
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic v, input logic clr);
    logic [15:0] r;
    logic p, n;
    @(negedge clk);
    a = x; b = y; in_valid = v; cnt_clr = clr;
    #1 chk_comb(tag);
    model(x, y, r, p, n);
    @(posedge clk);
    if (v) begin
      m_cq = r; m_pq = p; m_nq = n;
    end
    m_ov = v;
    if (clr) m_cnt = 0;
    else if (v && (p || n) && m_cnt < 65535) m_cnt++;
    #1 chk_reg(tag);
  endtask

  function automatic logic [15:0] rnd_operand();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0: return 16'(32767 - $urandom_range(0, 40));
      1: return 16'(-32768 + $urandom_range(0, 40));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    m_cq = '0; m_pq = 1'b0; m_nq = 1'b0; m_ov = 1'b0; m_cnt = 0;

    // reset state, combinational path live during reset
    a = 16'd3; b = -16'sd2;
    #3;
    chk_reg("reset");
    chk_comb("reset_comb");
    chk("reset.c_val", c, 16'd1);
    #10 rst = 1'b1;

    // directed combinational vectors
    step("d_3_m2",     16'd3,      -16'sd2,     1'b0, 1'b0);
    step("d_m30_m123", -16'sd30,   -16'sd123,   1'b0, 1'b0);
    chk("d_m30_m123.c_val", c, 16'hff67);
    step("d_pos_sat",  16'd32000,  16'd1000,    1'b0, 1'b0);
    chk("d_pos_sat.c_val", {c, sat_pos}, {16'h7fff, 1'b1});
    step("d_neg_sat",  -16'sd2000, -16'sd32500, 1'b0, 1'b0);
    chk("d_neg_sat.c_val", {c, sat_neg}, {16'h8000, 1'b1});
    step("d_exact_min", -16'sd32767, -16'sd1,   1'b0, 1'b0);
    chk("d_exact_min.c_val", {c, sat_pos, sat_neg}, {16'h8000, 2'b00});
    step("d_max_min",  16'd32767,  16'h8000,    1'b0, 1'b0);
    chk("d_max_min.c_val", {c, sat_pos, sat_neg}, {16'hffff, 2'b00});

    // registered path sequence
    step("r1", 16'd3,     16'd13,     1'b1, 1'b0);
    chk("r1.c_q_val", c_q, 16'd16);
    step("r2", 16'd32000, 16'd1000,   1'b1, 1'b0);
    step("r3", -16'sd30,  -16'sd123,  1'b1, 1'b0);
    chk("r3.cnt_val", sat_cnt, 16'd1);
    step("r_drop", 16'd32000, 16'd1000, 1'b0, 1'b0);
    chk("r_drop.hold", {c_q, out_valid, sat_cnt}, {16'hff67, 1'b0, 16'd1});

    // random traffic with occasional bubbles and clears
    for (int i = 0; i < 150; i++) begin
      step("rand", rnd_operand(), rnd_operand(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end

    // async reset pulse between edges
    step("pre_rst", 16'd32767, 16'd5, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m_cq = '0; m_pq = 1'b0; m_nq = 1'b0; m_ov = 1'b0; m_cnt = 0;
    chk_reg("async_rst");
    a = -16'sd100; b = 16'd40;
    #1 chk_comb("async_rst_comb");
    @(posedge clk);
    #1 chk_reg("rst_held");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    step("post_idle", 16'd7, 16'd8, 1'b0, 1'b0);
    step("post_first", 16'd7, 16'd8, 1'b1, 1'b0);
    chk("post_first.c_q_val", {c_q, out_valid}, {16'd15, 1'b1});

    // narrow counter: sticky at all-ones, clear wins over increment
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a2 = 16'd30000; b2 = 16'd30000; v2 = 1'b1; clr2 = 1'b0;
      @(posedge clk);
      #1 chk("cnt2_inc", cnt2, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    @(negedge clk);
    a2 = -16'sd30000; b2 = -16'sd30000; v2 = 1'b1; clr2 = 1'b1;
    @(posedge clk);
    #1 chk("cnt2_clr", {cnt2, sn2_q, ov2}, {2'd0, 1'b1, 1'b1});
    @(negedge clk);
    v2 = 1'b0; clr2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
